cpurv_mem_arbiter: RTL

Shares one single-port synchronous memory between the `cpurv` instruction-fetch path (`progaddress`/`instruction`) and its data load/store path (`dataoutport`/`datainport`). Each requester uses a req/ready accept handshake and receives a one-cycle valid response pulse. A small FSM sequences each access through the memory's fixed read latency. When both sides request in the same cycle, arbitration alternates so neither path starves.

---
 rtl/cpurv_mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cpurv_mem_arbiter.sv
// cpurv_mem_arbiter: shares one single-port sync memory between
// the fetch path and the load/store path with alternating priority.
module cpurv_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_ready,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t     state, state_n;
  logic       last_d, last_d_n;
  logic       owner_d, owner_d_n;
  logic [2:0] cnt, cnt_n;
  logic       idle_ok;
  logic       gnt_if, gnt_d;
  logic       expire;
  logic       unused;

  assign unused = ^{if_addr[1:0], d_addr[1:0]};

  assign busy    = (state == WAIT);
  assign idle_ok = (state == IDLE) && reset;
  assign expire  = (state == WAIT) && (cnt == 3'd1);

  // On a tie, last_d decides: the side not served last wins.
  assign gnt_if = idle_ok && if_req && (!d_req || last_d);
  assign gnt_d  = idle_ok && d_req && (!if_req || !last_d);

  assign if_ready = gnt_if;
  assign d_ready  = gnt_d;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : 4'hF;
      mem_addr  = d_addr[AW-1:2];
      mem_wdata = d_we ? d_wdata : '0;
    end else if (gnt_if) begin
      mem_en   = 1'b1;
      mem_be   = 4'hF;
      mem_addr = if_addr[AW-1:2];
    end
  end

  always_comb begin
    state_n   = state;
    last_d_n  = last_d;
    owner_d_n = owner_d;
    cnt_n     = cnt;
    unique case (state)
      IDLE: begin
        if (gnt_if || gnt_d) begin
          state_n   = WAIT;
          cnt_n     = 3'(MEM_LAT);
          owner_d_n = gnt_d;
          last_d_n  = gnt_d;
        end
      end
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (expire) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      owner_d  <= 1'b0;
      cnt      <= 3'd0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state    <= state_n;
      last_d   <= last_d_n;
      owner_d  <= owner_d_n;
      cnt      <= cnt_n;
      if_valid <= expire && !owner_d;
      d_valid  <= expire && owner_d;
      if (expire && !owner_d) if_rdata <= mem_rdata;
      if (expire && owner_d) d_rdata <= mem_rdata;
    end
  end

endmodule
